prod_bcd_conv: RTL and testbench



---
 rtl/prod_bcd_conv.sv | 131 +++++++++++++
 tb/tb_prod_bcd_conv.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prod_bcd_conv.sv
// Sequential binary-to-BCD converter (shift-add-3), one input bit per clock.
// Turns the multiplier product into hundreds/tens/ones digits for the display stage.
module prod_bcd_conv #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] p,
  output logic             busy,
  output logic             done,
  output logic [3:0]       bcd_hund,
  output logic [3:0]       bcd_tens,
  output logic [3:0]       bcd_ones,
  output logic [1:0]       dbg_state
);

  // Handshake: start is sampled only in IDLE; the accepting edge captures p and
  // raises busy; done pulses for exactly one cycle with bcd_* already valid, and
  // bcd_* then hold until the next completion. start seen while busy is dropped.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [3:0]       hund_q, hund_d;
  logic [3:0]       tens_q, tens_d;
  logic [3:0]       ones_q, ones_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [3:0]       out_hund_q, out_hund_d;
  logic [3:0]       out_tens_q, out_tens_d;
  logic [3:0]       out_ones_q, out_ones_d;

  logic [3:0] hund_adj, tens_adj, ones_adj;
  logic [3:0] hund_nx, tens_nx, ones_nx;

  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  // One double-dabble step: correct each digit, then shift the whole chain left.
  always_comb begin
    hund_adj = add3(hund_q);
    tens_adj = add3(tens_q);
    ones_adj = add3(ones_q);
    hund_nx  = {hund_adj[2:0], tens_adj[3]};
    tens_nx  = {tens_adj[2:0], ones_adj[3]};
    ones_nx  = {ones_adj[2:0], shreg_q[WIDTH-1]};
  end

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    hund_d     = hund_q;
    tens_d     = tens_q;
    ones_d     = ones_q;
    cnt_d      = cnt_q;
    out_hund_d = out_hund_q;
    out_tens_d = out_tens_q;
    out_ones_d = out_ones_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          shreg_d = p;
          hund_d  = 4'd0;
          tens_d  = 4'd0;
          ones_d  = 4'd0;
          cnt_d   = 4'd0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        shreg_d = shreg_q << 1;
        hund_d  = hund_nx;
        tens_d  = tens_nx;
        ones_d  = ones_nx;
        cnt_d   = cnt_q + 4'd1;
        if (cnt_q == LAST_CNT) begin
          out_hund_d = hund_nx;
          out_tens_d = tens_nx;
          out_ones_d = ones_nx;
          state_d    = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      shreg_q    <= '0;
      hund_q     <= 4'd0;
      tens_q     <= 4'd0;
      ones_q     <= 4'd0;
      cnt_q      <= 4'd0;
      out_hund_q <= 4'd0;
      out_tens_q <= 4'd0;
      out_ones_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      hund_q     <= hund_d;
      tens_q     <= tens_d;
      ones_q     <= ones_d;
      cnt_q      <= cnt_d;
      out_hund_q <= out_hund_d;
      out_tens_q <= out_tens_d;
      out_ones_q <= out_ones_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign bcd_hund  = out_hund_q;
  assign bcd_tens  = out_tens_q;
  assign bcd_ones  = out_ones_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_prod_bcd_conv.sv
// Bench for prod_bcd_conv: randomized and directed conversions checked against
// decimal arithmetic, plus handshake, input-capture and reset-abort scenarios.
module tb_prod_bcd_conv;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] p;
  logic         busy;
  logic         done;
  logic [3:0]   bcd_hund, bcd_tens, bcd_ones;
  logic [1:0]   dbg_state;

  int total = 0;
  int bad   = 0;

  prod_bcd_conv #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .p         (p),
    .busy      (busy),
    .done      (done),
    .bcd_hund  (bcd_hund),
    .bcd_tens  (bcd_tens),
    .bcd_ones  (bcd_ones),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // Reference: plain decimal digit extraction.
  function automatic logic [11:0] model(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [11:0] digits();
    return {bcd_hund, bcd_tens, bcd_ones};
  endfunction

  // Driver: one conversion; p is scrambled right after acceptance.
  task automatic run_conv(input logic [W-1:0] val, output int lat,
                          output logic [11:0] res, output logic pulse_one);
    @(negedge clk);
    p = val;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    p = W'($urandom);
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        lat = c;
        break;
      end
    end
    res = digits();
    @(posedge clk);
    @(negedge clk);
    pulse_one = (done === 1'b0) && (busy === 1'b0);
  endtask

  task automatic test_reset();
    logic [11:0] first;
    rst = 1'b1;
    start = 1'b0;
    p = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({busy, done} !== 2'b00) begin
      bad++;
      $display("FAIL reset_flags busy/done=%b required 00", {busy, done});
    end
    total++;
    if (digits() !== 12'h000) begin
      bad++;
      $display("FAIL reset_digits got %h required 000", digits());
    end
    first = digits();
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      @(negedge clk);
      total++;
      if (digits() !== first || busy !== 1'b0 || done !== 1'b0) begin
        bad++;
        $display("FAIL idle_hold cyc=%0d digits=%h busy=%b done=%b required %h/0/0",
                 c, digits(), busy, done, first);
      end
    end
  endtask

  task automatic check_list(input string name, input int vals[]);
    int lat;
    logic [11:0] res;
    logic one;
    foreach (vals[i]) begin
      run_conv(W'(vals[i]), lat, res, one);
      total++;
      if (res !== model(vals[i])) begin
        bad++;
        $display("FAIL %s_value p=%0d got %h required %h", name, vals[i], res, model(vals[i]));
      end
      total++;
      if (lat !== 8) begin
        bad++;
        $display("FAIL %s_latency p=%0d got %0d required 8", name, vals[i], lat);
      end
      total++;
      if (!one) begin
        bad++;
        $display("FAIL %s_pulse p=%0d done/busy not low one cycle after done", name, vals[i]);
      end
    end
  endtask

  task automatic test_products();
    check_list("product", '{12, 140, 225, 0});
  endtask

  task automatic test_boundary();
    check_list("boundary", '{255, 9, 10, 99, 100});
  endtask

  task automatic test_sweep();
    int order[256];
    int lat, j, tmp, errs;
    logic [11:0] res;
    logic one;
    for (int i = 0; i < 256; i++) order[i] = i;
    for (int i = 255; i > 0; i--) begin
      j = int'($urandom_range(0, i));
      tmp = order[i];
      order[i] = order[j];
      order[j] = tmp;
    end
    errs = 0;
    for (int i = 0; i < 256; i++) begin
      run_conv(W'(order[i]), lat, res, one);
      total++;
      if (res !== model(order[i]) || lat !== 8 || !one) begin
        bad++;
        errs++;
        if (errs < 10)
          $display("FAIL sweep p=%0d got %h lat=%0d required %h lat=8",
                   order[i], res, lat, model(order[i]));
      end
    end
  endtask

  task automatic test_ignored_start();
    int a, b, seen_at;
    logic [11:0] res;
    logic busy_late;
    a = int'($urandom_range(0, 255));
    b = (a + 1 + int'($urandom_range(0, 253))) % 256;
    @(negedge clk);
    p = W'(a);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    seen_at = -1;
    res = '0;
    busy_late = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (done && seen_at < 0) begin
        seen_at = c;
        res = digits();
      end
      if (c >= 10 && busy) busy_late = 1'b1;
      if (c == 3 || c == 8) begin
        start = 1'b1;
        p = W'(b);
      end else begin
        start = 1'b0;
      end
    end
    total++;
    if (seen_at !== 8) begin
      bad++;
      $display("FAIL ignore_latency got %0d required 8", seen_at);
    end
    total++;
    if (res !== model(a)) begin
      bad++;
      $display("FAIL ignore_value got %h required %h", res, model(a));
    end
    total++;
    if (busy_late !== 1'b0) begin
      bad++;
      $display("FAIL ignore_queued busy=1 required 0 after completion");
    end
  endtask

  task automatic test_back_to_back();
    int seen[$];
    @(negedge clk);
    p = W'(37);
    start = 1'b1;
    for (int c = 1; c <= 35; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        seen.push_back(c);
        total++;
        if (digits() !== 12'h037) begin
          bad++;
          $display("FAIL held_value cyc=%0d got %h required 037", c, digits());
        end
      end
    end
    start = 1'b0;
    total++;
    if (seen.size() !== 3) begin
      bad++;
      $display("FAIL held_count got %0d required 3", seen.size());
    end
    for (int i = 1; i < seen.size(); i++) begin
      total++;
      if (seen[i] - seen[i-1] !== 10) begin
        bad++;
        $display("FAIL held_period got %0d required 10", seen[i] - seen[i-1]);
      end
    end
    for (int c = 0; c < 30 && busy; c++) @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL held_drain busy=%b required 0", busy);
    end
  endtask

  task automatic test_p_change();
    int lat;
    logic [11:0] res;
    @(negedge clk);
    p = W'(200);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      p = (c == 2) ? W'(55) : W'($urandom);
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        lat = c;
        break;
      end
    end
    res = digits();
    total++;
    if (res !== 12'h200 || lat !== 8) begin
      bad++;
      $display("FAIL p_change got %h lat=%0d required 200 lat=8", res, lat);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [11:0] res;
    logic one, saw_done;
    @(negedge clk);
    p = W'(99);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({busy, done} !== 2'b00 || digits() !== 12'h000) begin
      bad++;
      $display("FAIL abort_state busy/done=%b digits=%h required 00/000", {busy, done}, digits());
    end
    saw_done = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    total++;
    if (saw_done !== 1'b0) begin
      bad++;
      $display("FAIL abort_nodone activity after abort, required none");
    end
    run_conv(W'(64), lat, res, one);
    total++;
    if (res !== 12'h064 || lat !== 8 || !one) begin
      bad++;
      $display("FAIL abort_restart got %h lat=%0d required 064 lat=8", res, lat);
    end
  endtask

  initial begin
    test_reset();
    test_products();
    test_boundary();
    test_ignored_start();
    test_back_to_back();
    test_p_change();
    test_reset_mid();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
